// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. Operands are accepted over a valid/ready
//   handshake, added one bit per clock (LSB first) through a single full-adder
//   cell built from two half-adder stages and an OR, and the WIDTH-bit sum
//   plus carry-out are returned over a second valid/ready handshake.
//
//   Optional build macro: SERIAL_ADDER_OVF_EN
//     When defined, adds a registered output 'ovf' that flags two's-complement
//     signed overflow of the completed addition.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q,   ovf_d;
`endif

    // Full-adder cell signals: two half-adder stages feeding an OR.
    logic ha1_s, ha1_c;
    logic ha2_s, ha2_c;
    logic fa_s,  fa_c;

    // Full-adder cell acting on the current LSBs of the operand shifters.
    always_comb begin
        ha1_s = a_sh_q[0] ^ b_sh_q[0];
        ha1_c = a_sh_q[0] & b_sh_q[0];
        ha2_s = ha1_s ^ carry_q;
        ha2_c = ha1_s & carry_q;
        fa_s  = ha2_s;
        fa_c  = ha1_c | ha2_c;
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a hold/default value first, so
        // no path through the case leaves one unassigned and no latch appears.
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // One bit per cycle: retire the LSBs, bring in the new sum bit
                // at the top of the sum shifter, and carry into the next bit.
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB, fa_c the carry out.
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end

            DONE: begin
                // Result is held until the consumer takes it; a new operand
                // request in this cycle is deliberately not accepted.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Result outputs come straight from registers.
    assign sum  = sum_q;
    assign cout = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder (WIDTH=8). The driver pushes the
//   expected result of every accepted operation into a queue; an independent
//   monitor pops and compares on every output handshake. Expected values come
//   from plain integer addition. Build with +define+SERIAL_ADDER_OVF_EN to
//   also check the signed-overflow output.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_hs  = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Reference: unsigned sum of the operands, signed overflow from sign bits.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv);
        int unsigned total;
        exp_t        e;
        total  = int'(av) + int'(bv) + int'(cv);
        e.sum  = W'(total % (1 << W));
        e.cout = (total >= (1 << W));
        e.ovf  = (av[W-1] == bv[W-1]) && (e.sum[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer readiness, changed shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare every result the DUT hands over against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got sum=0x%0h with no accepted operation", sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum",  64'(sum),  64'(mon_e.sum));
                check("cout", 64'(cout), 64'(mon_e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf",  64'(ovf),  64'(mon_e.ovf));
`endif
            end
        end
    end

    // Offer one operation; call just after a rising edge. Returns just after
    // the accepting edge with scrambled operand inputs.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int guard;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'(1));
        if (in_ready) begin
            @(posedge clk);
            exp_q.push_back(model(av, bv, cv));
            n_acc++;
        end
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
    endtask

    // Wait until every expected result has been consumed.
    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
    } op_t;

    op_t dir_ops[6];
    exp_t bp_e;
    int   cyc;

    initial begin
        dir_ops[0] = '{8'hFF, 8'h01, 1'b0};
        dir_ops[1] = '{8'hFF, 8'hFF, 1'b1};
        dir_ops[2] = '{8'h7F, 8'h01, 1'b0};
        dir_ops[3] = '{8'h80, 8'h80, 1'b0};
        dir_ops[4] = '{8'h00, 8'h00, 1'b1};
        dir_ops[5] = '{8'hAA, 8'h55, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // Reset state, sampled while reset is held.
        #12;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum",       64'(sum),       64'(0));
        check("rst_cout",      64'(cout),      64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf",       64'(ovf),       64'(0));
`endif
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First operation and its latency from the accepting edge.
        send(8'h5A, 8'h3C, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 50);
        check("latency", 64'(cyc), 64'(W + 1));
        drain();

        // Directed boundary operands.
        foreach (dir_ops[i]) begin
            send(dir_ops[i].a, dir_ops[i].b, dir_ops[i].c);
        end
        drain();

        // Backpressure: result held in DONE while inputs churn.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        bp_e = model(8'hA5, 8'h6B, 1'b1);
        send(8'hA5, 8'h6B, 1'b1);
        in_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 50);
        check("bp_reached_done", 64'(out_valid), 64'(1));
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_sum",       64'(sum),       64'(bp_e.sum));
            check("bp_cout",      64'(cout),      64'(bp_e.cout));
            @(posedge clk);
            #1;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
        end
        // Release with in_valid still high: the handshake must not also accept.
        @(posedge clk);
        #1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("no_accept_in_done", 64'(in_ready),  64'(1));
        check("idle_after_hs",     64'(out_valid), 64'(0));
        drain();

        // Asynchronous reset in the middle of RUN.
        send(8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(in_ready),  64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_sum",       64'(sum),       64'(0));
        check("midrst_cout",      64'(cout),      64'(0));
        exp_q.delete();
        n_acc--;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01, 8'h02, 1'b0);
        drain();

        // Random operations with random consumer stalls and idle gaps.
        rdy_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        check("handshake_count", 64'(n_hs), 64'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
